decode_stage_p: RTL and testbench
=================================

DECODE_STAGE_P -- requirements
Module: decode_stage_p

Interface
REQ-001 Parameter XLEN, default 64, data word width in bits.
REQ-002 Parameter NREG, default 15, number of architectural registers (IDs 0..NREG-1); ID 4'hF = RNONE.
REQ-003 Parameter RSP_INIT, default 64'd0, reset value of register 4 (%rsp).
REQ-004 clk  in  1  single clock; all state updates on posedge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 D_icode, D_ifun, D_rA, D_rB, D_stat  in  4 each  D-register fields.
REQ-007 D_valC, D_valP  in  XLEN  D-register constant and next-PC values.
REQ-008 e_dstE, M_dstE, M_dstM, W_dstE, W_dstM  in  4 each  forwarding destination IDs.
REQ-009 e_valE, M_valE, m_valM, W_valE, W_valM  in  XLEN  forwarding and writeback data.
REQ-010 E_bubble, E_stall  in  1 each  pipeline control for the E register.
REQ-011 E_stat, E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB  out  4 each  registered E fields.
REQ-012 E_valC, E_valA, E_valB  out  XLEN  registered E data.
REQ-013 d_srcA, d_srcB  out  4 each  combinational source IDs of the current D instruction.
REQ-014 d_loaduse  out  1  combinational load/use hazard flag.
REQ-015 reg_dump  out  NREG*XLEN  flat register-file image; register i at bits [i*XLEN +: XLEN].

Function
REQ-016 icode map: 0 halt, 1 nop, 2 rrmovq/cmovXX, 3 irmovq, 4 rmmovq, 5 mrmovq, 6 OPq, 7 jXX, 8 call, 9 ret, A pushq, B popq.
REQ-017 d_srcA SHALL be rA for icode 2,4,6,A; 4 for icode 9,B; else F.
REQ-018 d_srcB SHALL be rB for icode 4,5,6; 4 for icode 8,9,A,B; else F.
REQ-019 Decoded dstE SHALL be rB for icode 2,3,6; 4 for icode 8,9,A,B; else F.
REQ-020 Decoded dstM SHALL be rA for icode 5,B; else F.
REQ-021 Forwarded value for a source ID S != F, first match wins: e_dstE->e_valE, M_dstM->m_valM, M_dstE->M_valE, W_dstM->W_valM, W_dstE->W_valE, else register file; S == F yields 0.
REQ-022 Next valA SHALL be D_valP for icode 7 or 8, else forwarded value of d_srcA; next valB SHALL be forwarded value of d_srcB.
REQ-023 Register file SHALL write W_valE to W_dstE and W_valM to W_dstM on posedge when the ID is < NREG; IDs >= NREG (including F) are ignored.
REQ-024 When W_dstE == W_dstM (both valid), W_valM SHALL be written.
REQ-025 A decode read in the same cycle as a write to the same register SHALL receive the new value through forwarding (REQ-021), never the stale array value.
REQ-026 E register update priority per posedge: E_stall holds all E outputs; else E_bubble loads bubble; else loads decoded values; E_stall overrides E_bubble.
REQ-027 Bubble SHALL be: icode 1, ifun 0, stat 4'd1, dstE/dstM/srcA/srcB F, valC/valA/valB 0.
REQ-028 Latency: D inputs appear on E outputs exactly one posedge later.
REQ-029 d_loaduse SHALL be 1 iff E_icode is 5 or B and E_dstM != F and E_dstM equals d_srcA or d_srcB.
REQ-030 All arithmetic-free; all data paths exactly XLEN wide, no truncation or extension.

Reset
REQ-031 On reset assertion, immediately and independent of clk: E register takes bubble values (REQ-027), registers 0..NREG-1 cleared to 0 except register 4 = RSP_INIT.
REQ-032 While reset is high, writeback and E updates SHALL be suppressed; first update occurs on the first posedge after deassertion.
REQ-033 Reset asserted mid-operation SHALL discard any pending writeback of that cycle.

Verification
REQ-034 Reset with RSP_INIT=256 -> reg_dump reg4=256, all other registers 0, E_icode=1, E_dstE=F.
REQ-035 W_dstE=3,W_valE=7 one cycle, then D irmovq... OPq rA=3,rB=3 -> E_valA=7, E_valB=7 one posedge later.
REQ-036 D OPq rA=2 with e_dstE=2,e_valE=5 and M_dstE=2,M_valE=9 -> E_valA=5 (e has priority).
REQ-037 E holds mrmovq dstM=6, D OPq rA=6 -> d_loaduse=1; with E_bubble=1 next E_icode=1, dstE=F.
REQ-038 W_dstE=W_dstM=4, W_valE=1, W_valM=2 -> reg4=2 after posedge; E_stall=1 with E_bubble=1 -> E outputs unchanged.
REQ-039 D call, D_valP=64'h40 -> E_valA=64'h40, E_srcB=4, E_dstE=4.

Source files
------------

// File: rtl/decode_stage_p.sv
// Y86-64 style decode stage: register file, operand forwarding, load/use detection
// and the E pipeline register that feeds the execute stage.
module decode_stage_p #(
   parameter int unsigned     XLEN     = 64,
   parameter int unsigned     NREG     = 15,
   parameter logic [XLEN-1:0] RSP_INIT = '0
) (
   input  logic                 clk,
   input  logic                 reset,

   input  logic [3:0]           D_icode,
   input  logic [3:0]           D_ifun,
   input  logic [3:0]           D_rA,
   input  logic [3:0]           D_rB,
   input  logic [3:0]           D_stat,
   input  logic [XLEN-1:0]      D_valC,
   input  logic [XLEN-1:0]      D_valP,

   input  logic [3:0]           e_dstE,
   input  logic [3:0]           M_dstE,
   input  logic [3:0]           M_dstM,
   input  logic [3:0]           W_dstE,
   input  logic [3:0]           W_dstM,
   input  logic [XLEN-1:0]      e_valE,
   input  logic [XLEN-1:0]      M_valE,
   input  logic [XLEN-1:0]      m_valM,
   input  logic [XLEN-1:0]      W_valE,
   input  logic [XLEN-1:0]      W_valM,

   input  logic                 E_bubble,
   input  logic                 E_stall,

   output logic [3:0]           E_stat,
   output logic [3:0]           E_icode,
   output logic [3:0]           E_ifun,
   output logic [3:0]           E_dstE,
   output logic [3:0]           E_dstM,
   output logic [3:0]           E_srcA,
   output logic [3:0]           E_srcB,
   output logic [XLEN-1:0]      E_valC,
   output logic [XLEN-1:0]      E_valA,
   output logic [XLEN-1:0]      E_valB,

   output logic [3:0]           d_srcA,
   output logic [3:0]           d_srcB,
   output logic                 d_loaduse,

   output logic [NREG*XLEN-1:0] reg_dump
);

   localparam logic [3:0] RNONE    = 4'hF;
   localparam logic [3:0] RSP      = 4'h4;

   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] I_RRMOVQ = 4'h2;
   localparam logic [3:0] I_IRMOVQ = 4'h3;
   localparam logic [3:0] I_RMMOVQ = 4'h4;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_JXX    = 4'h7;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHQ  = 4'hA;
   localparam logic [3:0] I_POPQ   = 4'hB;

   localparam logic [3:0] STAT_BUB = 4'd1;

   logic [XLEN-1:0] regs_q [NREG];

   logic [3:0]      dst_e;
   logic [3:0]      dst_m;
   logic [XLEN-1:0] rf_a;
   logic [XLEN-1:0] rf_b;
   logic [XLEN-1:0] fwd_a;
   logic [XLEN-1:0] fwd_b;
   logic [XLEN-1:0] val_a;

   // ---------------------------------------------------------------
   // Register ID decode
   // ---------------------------------------------------------------
   always_comb begin
      d_srcA = RNONE;
      case (D_icode)
         I_RRMOVQ, I_RMMOVQ, I_OPQ, I_PUSHQ: d_srcA = D_rA;
         I_RET, I_POPQ:                      d_srcA = RSP;
         default:                            d_srcA = RNONE;
      endcase
   end

   always_comb begin
      d_srcB = RNONE;
      case (D_icode)
         I_RMMOVQ, I_MRMOVQ, I_OPQ:          d_srcB = D_rB;
         I_CALL, I_RET, I_PUSHQ, I_POPQ:     d_srcB = RSP;
         default:                            d_srcB = RNONE;
      endcase
   end

   always_comb begin
      dst_e = RNONE;
      case (D_icode)
         I_RRMOVQ, I_IRMOVQ, I_OPQ:          dst_e = D_rB;
         I_CALL, I_RET, I_PUSHQ, I_POPQ:     dst_e = RSP;
         default:                            dst_e = RNONE;
      endcase
   end

   always_comb begin
      dst_m = RNONE;
      case (D_icode)
         I_MRMOVQ, I_POPQ:                   dst_m = D_rA;
         default:                            dst_m = RNONE;
      endcase
   end

   // ---------------------------------------------------------------
   // Register file read (IDs at or above NREG read as zero)
   // ---------------------------------------------------------------
   always_comb begin
      rf_a = '0;
      rf_b = '0;
      for (int unsigned i = 0; i < NREG; i++) begin
         if (d_srcA == 4'(i)) rf_a = regs_q[i];
         if (d_srcB == 4'(i)) rf_b = regs_q[i];
      end
   end

   // ---------------------------------------------------------------
   // Forwarding: youngest producer wins; the W entries also cover a
   // same-cycle writeback so the stale array value is never used.
   // ---------------------------------------------------------------
   always_comb begin
      fwd_a = rf_a;
      if (d_srcA == RNONE)       fwd_a = '0;
      else if (d_srcA == e_dstE) fwd_a = e_valE;
      else if (d_srcA == M_dstM) fwd_a = m_valM;
      else if (d_srcA == M_dstE) fwd_a = M_valE;
      else if (d_srcA == W_dstM) fwd_a = W_valM;
      else if (d_srcA == W_dstE) fwd_a = W_valE;
   end

   always_comb begin
      fwd_b = rf_b;
      if (d_srcB == RNONE)       fwd_b = '0;
      else if (d_srcB == e_dstE) fwd_b = e_valE;
      else if (d_srcB == M_dstM) fwd_b = m_valM;
      else if (d_srcB == M_dstE) fwd_b = M_valE;
      else if (d_srcB == W_dstM) fwd_b = W_valM;
      else if (d_srcB == W_dstE) fwd_b = W_valE;
   end

   always_comb begin
      val_a = fwd_a;
      if (D_icode == I_JXX || D_icode == I_CALL) val_a = D_valP;
   end

   // ---------------------------------------------------------------
   // Load/use hazard against the load currently in E
   // ---------------------------------------------------------------
   always_comb begin
      d_loaduse = 1'b0;
      if ((E_icode == I_MRMOVQ || E_icode == I_POPQ) && (E_dstM != RNONE) &&
          (E_dstM == d_srcA || E_dstM == d_srcB)) begin
         d_loaduse = 1'b1;
      end
   end

   // ---------------------------------------------------------------
   // Register file write; dstM assigned last so it wins a collision
   // ---------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < NREG; i++) begin
            regs_q[i] <= (i == 32'd4) ? RSP_INIT : '0;
         end
      end else begin
         for (int unsigned i = 0; i < NREG; i++) begin
            if (W_dstE == 4'(i)) regs_q[i] <= W_valE;
            if (W_dstM == 4'(i)) regs_q[i] <= W_valM;
         end
      end
   end

   for (genvar g = 0; g < NREG; g++) begin : g_dump
      assign reg_dump[g*XLEN +: XLEN] = regs_q[g];
   end

   // ---------------------------------------------------------------
   // E pipeline register: stall beats bubble beats load
   // ---------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         E_stat  <= STAT_BUB;
         E_icode <= I_NOP;
         E_ifun  <= 4'h0;
         E_dstE  <= RNONE;
         E_dstM  <= RNONE;
         E_srcA  <= RNONE;
         E_srcB  <= RNONE;
         E_valC  <= '0;
         E_valA  <= '0;
         E_valB  <= '0;
      end else if (!E_stall) begin
         if (E_bubble) begin
            E_stat  <= STAT_BUB;
            E_icode <= I_NOP;
            E_ifun  <= 4'h0;
            E_dstE  <= RNONE;
            E_dstM  <= RNONE;
            E_srcA  <= RNONE;
            E_srcB  <= RNONE;
            E_valC  <= '0;
            E_valA  <= '0;
            E_valB  <= '0;
         end else begin
            E_stat  <= D_stat;
            E_icode <= D_icode;
            E_ifun  <= D_ifun;
            E_dstE  <= dst_e;
            E_dstM  <= dst_m;
            E_srcA  <= d_srcA;
            E_srcB  <= d_srcB;
            E_valC  <= D_valC;
            E_valA  <= val_a;
            E_valB  <= fwd_b;
         end
      end
   end

endmodule

// File: tb/tb_decode_stage_p.sv
// Bench for decode_stage_p: directed scenarios plus random instruction streams
// checked against a table-driven reference model of decode, forwarding and writeback.
module tb_decode_stage_p;

   localparam int unsigned XLEN = 64;
   localparam int unsigned NREG = 15;
   localparam logic [63:0] RSPI = 64'd256;
   localparam logic [3:0]  F    = 4'hF;

   logic            clk, reset;
   logic [3:0]      D_icode, D_ifun, D_rA, D_rB, D_stat;
   logic [63:0]     D_valC, D_valP;
   logic [3:0]      e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
   logic [63:0]     e_valE, M_valE, m_valM, W_valE, W_valM;
   logic            E_bubble, E_stall;
   logic [3:0]      E_stat, E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB;
   logic [63:0]     E_valC, E_valA, E_valB;
   logic [3:0]      d_srcA, d_srcB;
   logic            d_loaduse;
   logic [NREG*XLEN-1:0] reg_dump;

   int vecs = 0;
   int errs = 0;

   // reference model state
   logic [63:0] mreg [16];
   logic [3:0]  m_stat, m_icode, m_ifun, m_dstE, m_dstM, m_srcA, m_srcB;
   logic [63:0] m_valC, m_valA, m_valB;

   decode_stage_p #(.XLEN(XLEN), .NREG(NREG), .RSP_INIT(RSPI)) dut (
      .clk(clk), .reset(reset),
      .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB), .D_stat(D_stat),
      .D_valC(D_valC), .D_valP(D_valP),
      .e_dstE(e_dstE), .M_dstE(M_dstE), .M_dstM(M_dstM), .W_dstE(W_dstE), .W_dstM(W_dstM),
      .e_valE(e_valE), .M_valE(M_valE), .m_valM(m_valM), .W_valE(W_valE), .W_valM(W_valM),
      .E_bubble(E_bubble), .E_stall(E_stall),
      .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun), .E_dstE(E_dstE), .E_dstM(E_dstM),
      .E_srcA(E_srcA), .E_srcB(E_srcB), .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB),
      .d_srcA(d_srcA), .d_srcB(d_srcB), .d_loaduse(d_loaduse), .reg_dump(reg_dump)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout required finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // ---- specification tables ----
   function automatic logic [3:0] ref_srcA(input logic [3:0] ic, input logic [3:0] ra);
      if (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) return ra;
      if (ic inside {4'h9, 4'hB}) return 4'd4;
      return F;
   endfunction

   function automatic logic [3:0] ref_srcB(input logic [3:0] ic, input logic [3:0] rb);
      if (ic inside {4'h4, 4'h5, 4'h6}) return rb;
      if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'd4;
      return F;
   endfunction

   function automatic logic [3:0] ref_dstE(input logic [3:0] ic, input logic [3:0] rb);
      if (ic inside {4'h2, 4'h3, 4'h6}) return rb;
      if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'd4;
      return F;
   endfunction

   function automatic logic [3:0] ref_dstM(input logic [3:0] ic, input logic [3:0] ra);
      if (ic inside {4'h5, 4'hB}) return ra;
      return F;
   endfunction

   function automatic logic [63:0] ref_fwd(input logic [3:0] s);
      logic [3:0]  d [5];
      logic [63:0] v [5];
      d = '{e_dstE, M_dstM, M_dstE, W_dstM, W_dstE};
      v = '{e_valE, m_valM, M_valE, W_valM, W_valE};
      if (s == F) return 64'd0;
      for (int k = 0; k < 5; k++) if (d[k] == s) return v[k];
      return mreg[s];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 16; i++) mreg[i] = 64'd0;
      mreg[4] = RSPI;
      m_stat = 4'd1; m_icode = 4'd1; m_ifun = 4'd0;
      m_dstE = F; m_dstM = F; m_srcA = F; m_srcB = F;
      m_valC = 64'd0; m_valA = 64'd0; m_valB = 64'd0;
   endtask

   task automatic check_state(input string tag);
      chk({tag, ".E_stat"},  {60'd0, E_stat},  {60'd0, m_stat});
      chk({tag, ".E_icode"}, {60'd0, E_icode}, {60'd0, m_icode});
      chk({tag, ".E_ifun"},  {60'd0, E_ifun},  {60'd0, m_ifun});
      chk({tag, ".E_dstE"},  {60'd0, E_dstE},  {60'd0, m_dstE});
      chk({tag, ".E_dstM"},  {60'd0, E_dstM},  {60'd0, m_dstM});
      chk({tag, ".E_srcA"},  {60'd0, E_srcA},  {60'd0, m_srcA});
      chk({tag, ".E_srcB"},  {60'd0, E_srcB},  {60'd0, m_srcB});
      chk({tag, ".E_valC"},  E_valC, m_valC);
      chk({tag, ".E_valA"},  E_valA, m_valA);
      chk({tag, ".E_valB"},  E_valB, m_valB);
      for (int i = 0; i < 15; i++)
         chk($sformatf("%s.reg%0d", tag, i), reg_dump[i*64 +: 64], mreg[i]);
   endtask

   task automatic idle_inputs();
      D_icode = 4'h1; D_ifun = 4'h0; D_rA = F; D_rB = F; D_stat = 4'd1;
      D_valC = 64'd0; D_valP = 64'd0;
      e_dstE = F; M_dstE = F; M_dstM = F; W_dstE = F; W_dstM = F;
      e_valE = 64'd0; M_valE = 64'd0; m_valM = 64'd0; W_valE = 64'd0; W_valM = 64'd0;
      E_bubble = 1'b0; E_stall = 1'b0;
   endtask

   // Called just after a negedge with inputs already applied; ends on the next negedge.
   task automatic step(input string tag);
      logic [3:0]  sa, sb, n_dE, n_dM;
      logic [63:0] n_vA, n_vB;
      logic        lu;
      #1;
      sa = ref_srcA(D_icode, D_rA);
      sb = ref_srcB(D_icode, D_rB);
      lu = (m_icode inside {4'h5, 4'hB}) && (m_dstM != F) && (m_dstM == sa || m_dstM == sb);
      chk({tag, ".d_srcA"},    {60'd0, d_srcA},    {60'd0, sa});
      chk({tag, ".d_srcB"},    {60'd0, d_srcB},    {60'd0, sb});
      chk({tag, ".d_loaduse"}, {63'd0, d_loaduse}, {63'd0, lu});
      n_dE = ref_dstE(D_icode, D_rB);
      n_dM = ref_dstM(D_icode, D_rA);
      n_vA = (D_icode inside {4'h7, 4'h8}) ? D_valP : ref_fwd(sa);
      n_vB = ref_fwd(sb);
      @(posedge clk);
      #1;
      if (!E_stall) begin
         if (E_bubble) begin
            m_stat = 4'd1; m_icode = 4'd1; m_ifun = 4'd0;
            m_dstE = F; m_dstM = F; m_srcA = F; m_srcB = F;
            m_valC = 64'd0; m_valA = 64'd0; m_valB = 64'd0;
         end else begin
            m_stat = D_stat; m_icode = D_icode; m_ifun = D_ifun;
            m_dstE = n_dE; m_dstM = n_dM; m_srcA = sa; m_srcB = sb;
            m_valC = D_valC; m_valA = n_vA; m_valB = n_vB;
         end
      end
      if (W_dstE != F) mreg[W_dstE] = W_valE;
      if (W_dstM != F) mreg[W_dstM] = W_valM;
      check_state(tag);
      @(negedge clk);
   endtask

   function automatic logic [3:0] rnd_id();
      return ($urandom_range(0, 1) == 0) ? F : 4'($urandom_range(0, 14));
   endfunction

   task automatic rand_inputs();
      D_icode = 4'($urandom_range(0, 15)); D_ifun = 4'($urandom);
      D_rA = 4'($urandom_range(0, 15)); D_rB = 4'($urandom_range(0, 15));
      D_stat = 4'($urandom); D_valC = {$urandom, $urandom}; D_valP = {$urandom, $urandom};
      e_dstE = rnd_id(); M_dstE = rnd_id(); M_dstM = rnd_id();
      W_dstE = rnd_id(); W_dstM = rnd_id();
      e_valE = {$urandom, $urandom}; M_valE = {$urandom, $urandom};
      m_valM = {$urandom, $urandom}; W_valE = {$urandom, $urandom};
      W_valM = {$urandom, $urandom};
      E_stall = ($urandom_range(0, 9) == 0);
      E_bubble = ($urandom_range(0, 7) == 0);
   endtask

   task automatic apply_reset(input string tag);
      reset = 1'b1;
      model_reset();
      #1;
      check_state({tag, ".async"});
      @(posedge clk);
      #1;
      check_state({tag, ".held"});
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      idle_inputs();
      reset = 1'b0;
      #2;
      apply_reset("por");
      chk("rst.reg4",   reg_dump[4*64 +: 64], 64'd256);
      chk("rst.icode",  {60'd0, E_icode}, 64'd1);
      chk("rst.dstE",   {60'd0, E_dstE},  64'hF);

      // writeback then read through the register array
      idle_inputs(); W_dstE = 4'd3; W_valE = 64'd7;
      step("wb3");
      idle_inputs(); D_icode = 4'h6; D_rA = 4'd3; D_rB = 4'd3;
      step("opq33");
      chk("opq33.valA", E_valA, 64'd7);
      chk("opq33.valB", E_valB, 64'd7);

      // execute-stage forward beats memory-stage forward
      idle_inputs(); D_icode = 4'h6; D_rA = 4'd2; D_rB = F;
      e_dstE = 4'd2; e_valE = 64'd5; M_dstE = 4'd2; M_valE = 64'd9;
      step("fwdprio");
      chk("fwdprio.valA", E_valA, 64'd5);

      // load/use hazard then bubble
      idle_inputs(); D_icode = 4'h5; D_rA = 4'd6; D_rB = 4'd1;
      step("mrmov");
      idle_inputs(); D_icode = 4'h6; D_rA = 4'd6; D_rB = 4'd1; E_bubble = 1'b1;
      #1;
      chk("lu.flag", {63'd0, d_loaduse}, 64'd1);
      step("lu");
      chk("lu.icode", {60'd0, E_icode}, 64'd1);
      chk("lu.dstE",  {60'd0, E_dstE},  64'hF);

      // dstE/dstM collision plus stall overriding bubble
      idle_inputs(); D_icode = 4'h8; W_dstE = 4'd4; W_dstM = 4'd4;
      W_valE = 64'd1; W_valM = 64'd2; E_stall = 1'b1; E_bubble = 1'b1;
      step("coll");
      chk("coll.reg4",  reg_dump[4*64 +: 64], 64'd2);
      chk("coll.icode", {60'd0, E_icode}, 64'd1);
      chk("coll.dstE",  {60'd0, E_dstE},  64'hF);

      // call passes valP through valA
      idle_inputs(); D_icode = 4'h8; D_valP = 64'h40;
      step("call");
      chk("call.valA", E_valA, 64'h40);
      chk("call.srcB", {60'd0, E_srcB}, 64'd4);
      chk("call.dstE", {60'd0, E_dstE}, 64'd4);

      for (int n = 0; n < 300; n++) begin
         rand_inputs();
         step($sformatf("rnd%0d", n));
         if (n == 150) begin
            // reset mid-run with a writeback pending
            rand_inputs(); W_dstE = 4'd3; W_valE = 64'hDEAD; W_dstM = 4'd7; W_valM = 64'hBEEF;
            apply_reset("midrst");
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
